// File: rtl/fpga_ps_loader.sv
// Passive-serial FPGA loader: Z80 port writes are double-buffered and shifted LSB-first onto
// DATA0/DCLK; once CONF_DONE rises, INIT_CLKS trailing clocks are issued before DONE.
module fpga_ps_loader #(
  parameter int DIV       = 2,
  parameter int INIT_CLKS = 10
) (
  input  logic       clkin,
  input  logic       coldres,
  input  logic       config_n,
  input  logic       status_n,
  input  logic       conf_done,
  input  logic       wr_stb,
  input  logic [7:0] wr_data,
  output logic       dclk,
  output logic       data0,
  output logic [7:0] stat
);
  localparam int              PW        = $clog2(INIT_CLKS + 1);
  localparam logic [3:0]      DIV_FULL  = 4'(DIV);
  localparam logic [3:0]      DIV_LAST  = 4'(DIV - 1);
  localparam logic [PW-1:0]   PULSES    = PW'(INIT_CLKS);
  localparam logic [PW-1:0]   ONE_PULSE = PW'(1);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_SHIFT, S_INIT, S_DONE, S_ERROR} state_t;

  state_t        state_q;
  logic [1:0]    st_sync_q, cd_sync_q;
  logic [7:0]    hold_q, shift_q;
  logic          full_q, ovr_q, err_q, done_q, cd_seen_q, dclk_q;
  logic [3:0]    div_q;
  logic [2:0]    bit_q;
  logic [PW-1:0] pulse_q;

  logic status_s, conf_s, phase_end, byte_end, to_init, reload_d;

  always_comb begin
    status_s  = st_sync_q[1];
    conf_s    = cd_sync_q[1];
    phase_end = (div_q == 4'd0);
    byte_end  = (state_q == S_SHIFT) && status_s && phase_end && dclk_q && (bit_q == 3'd7);
    to_init   = cd_seen_q || conf_s;
    // A hold->shift transfer frees the hold slot in the same cycle, so a coincident write is kept.
    reload_d  = full_q && (((state_q == S_READY) && status_s && !conf_s) || (byte_end && !to_init));
  end

  always_ff @(posedge clkin or posedge coldres) begin
    if (coldres) begin
      state_q   <= S_IDLE;
      st_sync_q <= 2'b00;
      cd_sync_q <= 2'b00;
      hold_q    <= 8'h00;
      shift_q   <= 8'h00;
      full_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cd_seen_q <= 1'b0;
      dclk_q    <= 1'b0;
      div_q     <= 4'd0;
      bit_q     <= 3'd0;
      pulse_q   <= '0;
    end else begin
      st_sync_q <= {st_sync_q[0], status_n};
      cd_sync_q <= {cd_sync_q[0], conf_done};
      if (!config_n) begin
        state_q   <= S_IDLE;
        hold_q    <= 8'h00;
        shift_q   <= 8'h00;
        full_q    <= 1'b0;
        ovr_q     <= 1'b0;
        err_q     <= 1'b0;
        done_q    <= 1'b0;
        cd_seen_q <= 1'b0;
        dclk_q    <= 1'b0;
        div_q     <= 4'd0;
        bit_q     <= 3'd0;
        pulse_q   <= '0;
      end else begin
        if (wr_stb && ((state_q == S_READY) || (state_q == S_SHIFT))) begin
          if (!full_q || reload_d) begin
            hold_q <= wr_data;
            full_q <= 1'b1;
          end else begin
            ovr_q <= 1'b1;
          end
        end
        case (state_q)
          S_IDLE: if (status_s) state_q <= S_READY;
          S_READY: begin
            if (!status_s) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              dclk_q  <= 1'b0;
            end else if (conf_s) begin
              state_q <= S_INIT;
              full_q  <= 1'b0;
              shift_q <= 8'hFF;
              div_q   <= DIV_LAST;
              dclk_q  <= 1'b0;
              pulse_q <= PULSES;
            end else if (full_q) begin
              // One extra low cycle on the first bit covers the hold->shift transfer.
              state_q   <= S_SHIFT;
              shift_q   <= hold_q;
              if (!wr_stb) full_q <= 1'b0;
              div_q     <= DIV_FULL;
              dclk_q    <= 1'b0;
              bit_q     <= 3'd0;
              cd_seen_q <= 1'b0;
            end
          end
          S_SHIFT: begin
            if (!status_s) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              dclk_q  <= 1'b0;
            end else begin
              if (conf_s) cd_seen_q <= 1'b1;
              if (phase_end) begin
                div_q  <= DIV_LAST;
                dclk_q <= !dclk_q;
                if (dclk_q) begin
                  shift_q <= {1'b0, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                    if (to_init) begin
                      state_q <= S_INIT;
                      full_q  <= 1'b0;
                      shift_q <= 8'hFF;
                      pulse_q <= PULSES;
                    end else if (full_q) begin
                      shift_q <= hold_q;
                      if (!wr_stb) full_q <= 1'b0;
                    end else begin
                      state_q <= S_READY;
                    end
                  end
                end
              end else begin
                div_q <= div_q - 4'd1;
              end
            end
          end
          S_INIT: begin
            if (!status_s) begin
              state_q <= S_ERROR;
              err_q   <= 1'b1;
              dclk_q  <= 1'b0;
            end else if (phase_end) begin
              div_q  <= DIV_LAST;
              dclk_q <= !dclk_q;
              if (dclk_q) begin
                pulse_q <= pulse_q - ONE_PULSE;
                if (pulse_q == ONE_PULSE) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
            end else begin
              div_q <= div_q - 4'd1;
            end
          end
          S_DONE:  dclk_q <= 1'b0;
          S_ERROR: dclk_q <= 1'b0;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign dclk  = dclk_q;
  assign data0 = shift_q[0];
  assign stat  = {done_q, err_q, ovr_q, full_q, 2'b00, status_s, conf_s};
endmodule

// File: tb/tb_fpga_ps_loader.sv
// Bench for fpga_ps_loader: random config bytes against an arithmetic model of the DCLK/DATA0 stream.
module tb_fpga_ps_loader;
  localparam int DIV       = 2;
  localparam int INIT_CLKS = 10;
  localparam int BIT_P     = 2 * DIV;
  localparam int FIRST     = DIV + 2;

  logic       clkin = 1'b0;
  logic       coldres, config_n, status_n, conf_done, wr_stb;
  logic [7:0] wr_data;
  logic       dclk, data0;
  logic [7:0] stat;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  int         rise_t[$];
  logic       rise_d[$];
  logic [7:0] exp_bytes[$];
  logic       prev_dclk = 1'b0;

  fpga_ps_loader #(.DIV(DIV), .INIT_CLKS(INIT_CLKS)) dut (
    .clkin    (clkin),
    .coldres  (coldres),
    .config_n (config_n),
    .status_n (status_n),
    .conf_done(conf_done),
    .wr_stb   (wr_stb),
    .wr_data  (wr_data),
    .dclk     (dclk),
    .data0    (data0),
    .stat     (stat)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
    if (dclk && !prev_dclk) begin
      rise_t.push_back(cyc);
      rise_d.push_back(data0);
    end
    prev_dclk = dclk;
  endtask

  task automatic run_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic strobe(input logic [7:0] b);
    wr_stb  = 1'b1;
    wr_data = b;
    tick();
    wr_stb  = 1'b0;
    wr_data = 8'($urandom);
  endtask

  task automatic clear_log();
    rise_t.delete();
    rise_d.delete();
  endtask

  task automatic pulse_config_n();
    config_n = 1'b0;
    tick();
    config_n = 1'b1;
    repeat (4) tick();
  endtask

  // Expected stream: bytes of exp_bytes LSB first, then `ones` trailing 1-bits, one rise per
  // 2*DIV cycles, the first rise DIV+2 cycles after the strobe edge s.
  task automatic check_rises(input string tag, input int s, input int ones);
    int   n;
    logic eb;
    n = exp_bytes.size() * 8 + ones;
    chk({tag, "_count"}, rise_t.size(), n);
    for (int i = 0; i < n && i < rise_t.size(); i++) begin
      eb = (i < exp_bytes.size() * 8) ? exp_bytes[i / 8][i % 8] : 1'b1;
      chk($sformatf("%s_time%0d", tag, i), rise_t[i], s + FIRST + BIT_P * i);
      chk($sformatf("%s_bit%0d", tag, i), rise_d[i], eb);
    end
    clear_log();
  endtask

  initial begin
    int         s;
    int         gap;
    logic [7:0] b1, b2, b3;

    coldres = 1'b1; config_n = 1'b1; status_n = 1'b1; conf_done = 1'b0;
    wr_stb = 1'b0; wr_data = 8'h00;
    #2;
    chk("rst_dclk", dclk, 1'b0);
    chk("rst_data0", data0, 1'b0);
    chk("rst_stat", stat, 8'h00);
    tick(); tick();
    chk("rst_hold_stat", stat, 8'h00);
    coldres = 1'b0;
    repeat (4) tick();
    chk("ready_stat", stat, 8'h02);
    clear_log();

    // Single bytes from READY.
    for (int k = 0; k < 3; k++) begin
      b1 = (k == 0) ? 8'hA5 : 8'($urandom);
      strobe(b1);
      s = cyc;
      chk("one_full_set", stat[4], 1'b1);
      tick();
      chk("one_full_clr", stat[4], 1'b0);
      run_until(s + 40);
      exp_bytes.delete(); exp_bytes.push_back(b1);
      check_rises($sformatf("one%0d", k), s, 0);
      chk("one_dclk_idle", dclk, 1'b0);
    end

    // Back-to-back bytes with a random strobe spacing inside the first byte.
    for (int k = 0; k < 2; k++) begin
      b1 = 8'($urandom); b2 = 8'($urandom);
      gap = (k == 0) ? 3 : $urandom_range(1, 30);
      strobe(b1);
      s = cyc;
      run_until(s + gap - 1);
      strobe(b2);
      chk("b2b_full", stat[4], 1'b1);
      run_until(s + 72);
      exp_bytes.delete(); exp_bytes.push_back(b1); exp_bytes.push_back(b2);
      check_rises($sformatf("b2b%0d", k), s, 0);
      chk("b2b_ovr", stat[5], 1'b0);
    end

    // Three strobes on consecutive cycles: the third is dropped.
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    strobe(b1);
    s = cyc;
    strobe(b2);
    strobe(b3);
    run_until(s + 5);
    chk("ovr_stat_shift", stat, 8'h32);
    run_until(s + 72);
    exp_bytes.delete(); exp_bytes.push_back(b1); exp_bytes.push_back(b2);
    check_rises("ovr", s, 0);
    chk("ovr_sticky", stat, 8'h22);
    pulse_config_n();
    chk("ovr_cleared", stat, 8'h02);

    // CONF_DONE during bit 3: byte completes, then trailing clocks, then DONE.
    b1 = 8'($urandom);
    strobe(b1);
    s = cyc;
    run_until(s + FIRST + 3 * BIT_P);
    conf_done = 1'b1;
    run_until(s + 90);
    exp_bytes.delete(); exp_bytes.push_back(b1);
    check_rises("init", s, INIT_CLKS);
    chk("done_stat", stat, 8'h83);
    chk("done_dclk", dclk, 1'b0);
    strobe(8'($urandom));
    repeat (10) tick();
    chk("done_ignore_stat", stat, 8'h83);
    chk("done_no_dclk", rise_t.size(), 0);
    conf_done = 1'b0;
    repeat (3) tick();
    pulse_config_n();
    chk("done_cleared", stat, 8'h02);
    clear_log();

    // nSTATUS low mid-byte.
    b1 = 8'($urandom);
    strobe(b1);
    s = cyc;
    run_until(s + 10);
    status_n = 1'b0;
    repeat (3) tick();
    chk("err_dclk", dclk, 1'b0);
    chk("err_stat", stat, 8'h40);
    repeat (20) tick();
    chk("err_rise_count", rise_t.size(), 3);
    status_n = 1'b1;
    repeat (4) tick();
    chk("err_held", stat, 8'h42);
    pulse_config_n();
    chk("err_cleared", stat, 8'h02);
    clear_log();
    b1 = 8'($urandom);
    strobe(b1);
    s = cyc;
    run_until(s + 40);
    exp_bytes.delete(); exp_bytes.push_back(b1);
    check_rises("after_err", s, 0);

    // Reset in the middle of a DCLK high phase.
    strobe(8'($urandom));
    s = cyc;
    run_until(s + FIRST + 1);
    chk("crst_pre_dclk", dclk, 1'b1);
    coldres = 1'b1;
    #1;
    chk("crst_dclk", dclk, 1'b0);
    chk("crst_data0", data0, 1'b0);
    chk("crst_stat_hi", stat[7:4], 4'h0);
    tick(); tick();
    coldres = 1'b0;
    clear_log();
    repeat (20) tick();
    chk("crst_no_dclk", rise_t.size(), 0);
    chk("crst_ready", stat, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
